// File: rtl/button_conditioner.sv
// Player push-button input stage for the whack-a-mole controller.
// Each raw button goes through a two-flop synchroniser and a stable-count debouncer.
// Registered press/release pulses come out of the debouncer, and a combinational
// decode gives a single press index so one physical hit scores at most once.

module button_conditioner #(
   parameter int unsigned N_BTN     = 4,
   parameter int unsigned DB_CYCLES = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             press_valid,
   output logic [1:0]       press_idx,
   output logic             multi_press
);

   // Terminal count: a mismatch seen at this count is the DB_CYCLES-th in a row.
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;
   logic [N_BTN-1:0] level_q;
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] press_q;
   logic [N_BTN-1:0] press_d;
   logic [N_BTN-1:0] release_q;
   logic [N_BTN-1:0] release_d;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];

   // Two-flop synchroniser for the asynchronous button levels.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Per-channel debounce: count consecutive mismatches and accept the new level
   // on the edge where the run reaches DB_CYCLES. Pulses are decided on the same edge.
   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               // Run complete: flip the level and restart counting from zero.
               level_d[i]   = sync2_q[i];
               press_d[i]   = sync2_q[i];
               release_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state, accepted levels and registered edge pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

   // Press decode straight from the pulse registers; lowest channel wins.
   always_comb begin
      press_idx = 2'd0;
      for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
         if (press_q[i]) begin
            press_idx = 2'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign press_valid = |press_q;
   assign multi_press = |(press_q & (press_q - 1'b1));

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner, checked against a
// history-based reference model of the debounce rules.

module tb_button_conditioner;

   localparam int N  = 4;
   localparam int DB = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic         press_valid;
   logic [1:0]   press_idx;
   logic         multi_press;

   int tests = 0;
   int fails = 0;

   button_conditioner #(
      .N_BTN     (N),
      .DB_CYCLES (DB),
      .CNT_W     (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .press_valid (press_valid),
      .press_idx   (press_idx),
      .multi_press (multi_press)
   );

   always #5 clock = ~clock;

   wire [15:0] got = {btn_level, btn_press, btn_release, press_valid, press_idx, multi_press};

   // Reference model: raw samples taken at each edge; the debouncer sees the one
   // taken two edges earlier. A level flips after DB consecutive disagreeing samples.
   logic [N-1:0] hist [$];
   int           m_run [N];
   logic [N-1:0] m_level;
   logic [N-1:0] m_press;
   logic [N-1:0] m_rel;

   function automatic void model_clear();
      hist.delete();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endfunction

   function automatic void model_step();
      logic [N-1:0] seen;
      m_press = '0;
      m_rel   = '0;
      if (reset) begin
         model_clear();
         return;
      end
      seen = (hist.size() >= 2) ? hist[hist.size() - 2] : '0;
      hist.push_back(btn_raw);
      if (hist.size() > 4) void'(hist.pop_front());
      for (int i = 0; i < N; i++) begin
         if (seen[i] == m_level[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
               m_level[i] = seen[i];
               m_run[i]   = 0;
               if (seen[i]) m_press[i] = 1'b1;
               else         m_rel[i]   = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [15:0] model_vec();
      logic [1:0] idx;
      bit         found;
      idx   = 2'd0;
      found = 0;
      for (int i = 0; i < N; i++) begin
         if (!found && m_press[i]) begin
            idx   = 2'(i);
            found = 1;
         end
      end
      return {m_level, m_press, m_rel, found, idx, ($countones(m_press) > 1)};
   endfunction

   // Advance one clock: model sees the inputs at the edge, outputs are sampled at negedge.
   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic settle();
      btn_raw = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL settle c=%0d got=%h exp=%h", c, got, model_vec());
         end
      end
   endtask

   task automatic test_reset();
      btn_raw = 4'b1111;
      #1 reset = 1'b1;
      model_clear();
      #1;
      tests++;
      if (got !== 16'h0) begin
         fails++;
         $display("FAIL reset_async got=%h exp=0000", got);
      end
      for (int c = 0; c < 3; c++) tick();
      tests++;
      if (got !== 16'h0) begin
         fails++;
         $display("FAIL reset_held got=%h exp=0000", got);
      end
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL reset_model c=%0d got=%h exp=%h", c, got, model_vec());
         end
         tests++;
         if (c == 6) begin
            if (btn_press !== 4'b1111 || multi_press !== 1'b1 || press_idx !== 2'd0) begin
               fails++;
               $display("FAIL reset_press c=%0d got press=%b multi=%b idx=%0d exp 1111/1/0",
                        c, btn_press, multi_press, press_idx);
            end
         end else if (btn_press !== 4'b0000) begin
            fails++;
            $display("FAIL reset_nopulse c=%0d got press=%b exp 0000", c, btn_press);
         end
      end
   endtask

   task automatic test_clean_press();
      btn_raw[2] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL clean_model c=%0d got=%h exp=%h", c, got, model_vec());
         end
         tests++;
         if (c == 6) begin
            if (btn_press !== 4'b0100 || press_idx !== 2'd2 || press_valid !== 1'b1) begin
               fails++;
               $display("FAIL clean_press c=%0d got press=%b idx=%0d valid=%b exp 0100/2/1",
                        c, btn_press, press_idx, press_valid);
            end
         end else if (btn_press !== 4'b0000 || btn_level[2] !== (c > 6)) begin
            fails++;
            $display("FAIL clean_hold c=%0d got press=%b lvl2=%b exp 0000/%0d",
                     c, btn_press, btn_level[2], (c > 6));
         end
      end
   endtask

   task automatic test_release();
      btn_raw[2] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL release_model c=%0d got=%h exp=%h", c, got, model_vec());
         end
         tests++;
         if (btn_release !== ((c == 6) ? 4'b0100 : 4'b0000) || btn_press !== 4'b0000 ||
             btn_level[2] !== (c < 6)) begin
            fails++;
            $display("FAIL release_pulse c=%0d got rel=%b press=%b lvl2=%b", c, btn_release,
                     btn_press, btn_level[2]);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      pat = 5'b01101;  // 1,0,1,1,0 sent LSB first
      for (int k = 0; k < 5; k++) begin
         btn_raw[1] = pat[k];
         tick();
         tests++;
         if (btn_press !== 4'b0000 || got !== model_vec()) begin
            fails++;
            $display("FAIL bounce_quiet k=%0d got=%h exp=%h", k, got, model_vec());
         end
      end
      btn_raw[1] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL bounce_model c=%0d got=%h exp=%h", c, got, model_vec());
         end
         tests++;
         if (btn_press !== ((c == 6) ? 4'b0010 : 4'b0000)) begin
            fails++;
            $display("FAIL bounce_press c=%0d got press=%b exp %b", c, btn_press,
                     (c == 6) ? 4'b0010 : 4'b0000);
         end
      end
   endtask

   task automatic test_glitch();
      for (int c = 1; c <= 14; c++) begin
         btn_raw[3] = (c <= 3);
         tick();
         tests++;
         if (btn_level[3] !== 1'b0 || btn_press[3] !== 1'b0 || got !== model_vec()) begin
            fails++;
            $display("FAIL glitch c=%0d got=%h exp=%h", c, got, model_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      btn_raw[0] = 1'b1;
      tick();
      tick();
      tick();
      tick();
      #2 reset = 1'b1;
      model_clear();
      #1;
      tests++;
      if (got !== 16'h0) begin
         fails++;
         $display("FAIL midreset_async got=%h exp=0000", got);
      end
      tick();
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         tests++;
         if (got !== model_vec() || btn_press !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
            fails++;
            $display("FAIL midreset_press c=%0d got=%h exp=%h", c, got, model_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] pats [4];
      pats[0] = 4'b1010;
      pats[1] = 4'b0110;
      pats[2] = 4'b1000;
      pats[3] = 4'b1101;
      for (int p = 0; p < 4; p++) begin
         btn_raw = pats[p];
         for (int c = 1; c <= 7; c++) begin
            tick();
            tests++;
            if (got !== model_vec()) begin
               fails++;
               $display("FAIL b2b_model p=%0d c=%0d got=%h exp=%h", p, c, got, model_vec());
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
         end
         reset = ($urandom_range(0, 399) == 0);
         tick();
         tests++;
         if (got !== model_vec()) begin
            fails++;
            $display("FAIL random c=%0d raw=%b got=%h exp=%h", c, btn_raw, got, model_vec());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      settle();
      test_clean_press();
      test_release();
      settle();
      test_bounce();
      settle();
      test_glitch();
      settle();
      test_reset_mid();
      settle();
      test_back_to_back();
      settle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
